// File: rtl/axil_reg_bridge.sv
// AXI4-Lite slave that maps a small bank of 32-bit registers onto a one-hot write strobe
// and a flat read bus; independent write (3-state) and read (2-state) FSMs.
//
// state  | meaning
// W_IDLE | accepting AW and W independently, in any order
// W_EXEC | one-cycle register write strobe (suppressed for bad index / empty strobe)
// W_RESP | BVALID held until BREADY
// R_IDLE | accepting AR; read data registered on the handshake
// R_DATA | RVALID held with stable RDATA/RRESP until RREADY
module axil_reg_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_REGS   = 8
) (
    input  logic                           CLK,
    input  logic                           RSTN,
    input  logic [ADDR_WIDTH-1:0]          AWADDR,
    input  logic                           AWVALID,
    output logic                           AWREADY,
    input  logic [DATA_WIDTH-1:0]          WDATA,
    input  logic [DATA_WIDTH/8-1:0]        WSTRB,
    input  logic                           WVALID,
    output logic                           WREADY,
    output logic [1:0]                     BRESP,
    output logic                           BVALID,
    input  logic                           BREADY,
    input  logic [ADDR_WIDTH-1:0]          ARADDR,
    input  logic                           ARVALID,
    output logic                           ARREADY,
    output logic [DATA_WIDTH-1:0]          RDATA,
    output logic [1:0]                     RRESP,
    output logic                           RVALID,
    input  logic                           RREADY,
    output logic [NUM_REGS-1:0]            REG_WEN,
    output logic [DATA_WIDTH-1:0]          REG_WDATA,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] REG_VALUES
);

    localparam int IDX_W  = ADDR_WIDTH - 2;
    localparam int STRB_W = DATA_WIDTH / 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_EXEC, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    function automatic logic idx_ok(input logic [IDX_W-1:0] idx);
        idx_ok = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx == IDX_W'(i)) idx_ok = 1'b1;
    endfunction

    function automatic logic [DATA_WIDTH-1:0] idx_val(input logic [IDX_W-1:0] idx,
                                                      input logic [NUM_REGS*DATA_WIDTH-1:0] vals);
        idx_val = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx == IDX_W'(i)) idx_val = vals[i*DATA_WIDTH +: DATA_WIDTH];
    endfunction

    function automatic logic [NUM_REGS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
        idx_onehot = '0;
        for (int i = 0; i < NUM_REGS; i++)
            if (idx == IDX_W'(i)) idx_onehot[i] = 1'b1;
    endfunction

    w_state_e                w_state_q;
    r_state_e                r_state_q;
    logic                    awready_q, wready_q, arready_q;
    logic                    aw_got_q, w_got_q;
    logic [IDX_W-1:0]        awidx_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [STRB_W-1:0]       wstrb_q;
    logic                    wr_err_q;
    logic [NUM_REGS-1:0]     reg_wen_q;
    logic [DATA_WIDTH-1:0]   reg_wdata_q;
    logic                    bvalid_q;
    logic [1:0]              bresp_q;
    logic                    rvalid_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              rresp_q;

    logic                    aw_hs, w_hs, ar_hs;
    logic                    aw_got_d, w_got_d;
    logic [IDX_W-1:0]        wr_idx, rd_idx;
    logic [DATA_WIDTH-1:0]   wr_data, wr_mask, wr_merge_d;
    logic [STRB_W-1:0]       wr_strb;
    logic                    wr_ok, rd_ok;
    logic [NUM_REGS-1:0]     wen_d;
    logic                    unused_addr_lsbs;

    // Byte offset within a register carries no meaning here.
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    assign aw_hs    = AWVALID & awready_q;
    assign w_hs     = WVALID & wready_q;
    assign ar_hs    = ARVALID & arready_q;
    assign aw_got_d = aw_got_q | aw_hs;
    assign w_got_d  = w_got_q | w_hs;

    // Use the live bus value on the handshake cycle so the strobe follows with one cycle latency.
    assign wr_idx  = aw_hs ? AWADDR[ADDR_WIDTH-1:2] : awidx_q;
    assign wr_data = w_hs ? WDATA : wdata_q;
    assign wr_strb = w_hs ? WSTRB : wstrb_q;
    assign wr_ok   = idx_ok(wr_idx);
    assign rd_idx  = ARADDR[ADDR_WIDTH-1:2];
    assign rd_ok   = idx_ok(rd_idx);

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < STRB_W; b++)
            wr_mask[b*8 +: 8] = {8{wr_strb[b]}};
    end

    assign wr_merge_d = (idx_val(wr_idx, REG_VALUES) & ~wr_mask) | (wr_data & wr_mask);
    assign wen_d      = (wr_ok && (|wr_strb)) ? idx_onehot(wr_idx) : '0;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            w_state_q   <= W_IDLE;
            awready_q   <= 1'b0;
            wready_q    <= 1'b0;
            aw_got_q    <= 1'b0;
            w_got_q     <= 1'b0;
            awidx_q     <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            wr_err_q    <= 1'b0;
            reg_wen_q   <= '0;
            reg_wdata_q <= '0;
            bvalid_q    <= 1'b0;
            bresp_q     <= RESP_OKAY;
        end else begin
            case (w_state_q)
                W_IDLE: begin
                    if (aw_hs) awidx_q <= AWADDR[ADDR_WIDTH-1:2];
                    if (w_hs) begin
                        wdata_q <= WDATA;
                        wstrb_q <= WSTRB;
                    end
                    if (aw_got_d && w_got_d) begin
                        w_state_q   <= W_EXEC;
                        aw_got_q    <= 1'b0;
                        w_got_q     <= 1'b0;
                        awready_q   <= 1'b0;
                        wready_q    <= 1'b0;
                        wr_err_q    <= ~wr_ok;
                        reg_wen_q   <= wen_d;
                        reg_wdata_q <= wr_merge_d;
                    end else begin
                        aw_got_q  <= aw_got_d;
                        w_got_q   <= w_got_d;
                        awready_q <= ~aw_got_d;
                        wready_q  <= ~w_got_d;
                    end
                end
                W_EXEC: begin
                    w_state_q <= W_RESP;
                    reg_wen_q <= '0;
                    bvalid_q  <= 1'b1;
                    bresp_q   <= wr_err_q ? RESP_SLVERR : RESP_OKAY;
                end
                W_RESP: begin
                    if (BREADY) begin
                        w_state_q <= W_IDLE;
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        wready_q  <= 1'b1;
                    end
                end
                default: begin
                    w_state_q <= W_IDLE;
                    reg_wen_q <= '0;
                    bvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    // Read path samples REG_VALUES on the AR handshake, so a same-cycle write returns the old value.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            case (r_state_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        r_state_q <= R_DATA;
                        arready_q <= 1'b0;
                        rvalid_q  <= 1'b1;
                        rdata_q   <= rd_ok ? idx_val(rd_idx, REG_VALUES) : '0;
                        rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
                    end else begin
                        arready_q <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (RREADY) begin
                        r_state_q <= R_IDLE;
                        rvalid_q  <= 1'b0;
                        arready_q <= 1'b1;
                    end
                end
                default: begin
                    r_state_q <= R_IDLE;
                    rvalid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign ARREADY   = arready_q;
    assign RVALID    = rvalid_q;
    assign RDATA     = rdata_q;
    assign RRESP     = rresp_q;
    assign REG_WEN   = reg_wen_q;
    assign REG_WDATA = reg_wdata_q;

endmodule

// File: doc/axil_reg_bridge.md
AXIL_REG_BRIDGE -- requirements
Module: axil_reg_bridge

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning AXI data and register width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_WIDTH, default 8, meaning byte-address width.
REQ-003 SHALL have parameter NUM_REGS, default 8, meaning number of attached registers; it is at most 2^(ADDR_WIDTH-2).
REQ-004 SHALL have one clock and an asynchronous, active-low reset.
- CLK  in  1  clock.
- RSTN  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have the AXI4-Lite write ports:
- AWADDR  in  ADDR_WIDTH
- AWVALID  in  1
- AWREADY  out  1
- WDATA  in  DATA_WIDTH
- WSTRB  in  DATA_WIDTH/8
- WVALID  in  1
- WREADY  out  1
- BRESP  out  2
- BVALID  out  1
- BREADY  in  1
REQ-006 SHALL have the AXI4-Lite read ports:
- ARADDR  in  ADDR_WIDTH
- ARVALID  in  1
- ARREADY  out  1
- RDATA  out  DATA_WIDTH
- RRESP  out  2
- RVALID  out  1
- RREADY  in  1
REQ-007 SHALL have the register-side ports:
- REG_WEN  out  NUM_REGS  one-hot write strobe, bit i drives register i's WEN.
- REG_WDATA  out  DATA_WIDTH  value to write, shared by all registers.
- REG_VALUES  in  NUM_REGS*DATA_WIDTH  current register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].

Function
REQ-008 SHALL decode the register index as addr[ADDR_WIDTH-1:2]; addr[1:0] is ignored; an index >= NUM_REGS is out of range.
REQ-009 SHALL run a write FSM with states W_IDLE, W_EXEC and W_RESP.
REQ-010 In W_IDLE, SHALL hold AWREADY=1 until the AW handshake and WREADY=1 until the W handshake; address and data are captured independently, in either order or in the same cycle.
REQ-011 SHALL leave W_IDLE for W_EXEC on the cycle after both AW and W have been captured.
REQ-012 In W_EXEC (exactly one cycle), SHALL assert REG_WEN[idx] for an in-range index and drive REG_WDATA = (old & ~mask) | (WDATA & mask), where old is the REG_VALUES slice and mask expands each WSTRB bit to a byte.
REQ-013 For an out-range index or WSTRB=0, SHALL keep REG_WEN at 0 and then go to W_RESP.
REQ-014 In W_RESP, SHALL hold BVALID=1 with BRESP=2'b00 (OKAY), or 2'b10 (SLVERR) for an out-range index, until BREADY=1, then return to W_IDLE.
REQ-015 SHALL keep AWREADY and WREADY at 0 outside W_IDLE (one outstanding write).
REQ-016 SHALL run a read FSM with states R_IDLE and R_DATA, independent of the write FSM.
REQ-017 In R_IDLE, SHALL hold ARREADY=1; on the AR handshake it registers RDATA from the REG_VALUES slice (0 when out of range) and RRESP (OKAY or SLVERR), and moves to R_DATA.
REQ-018 In R_DATA, SHALL hold RVALID=1 with RDATA and RRESP stable until RREADY=1, then return to R_IDLE; ARREADY is 0 in R_DATA.
REQ-019 On an AR handshake in the same cycle as REG_WEN, SHALL return the pre-write register value (REG_VALUES sampled that cycle).
REQ-020 SHALL produce minimum latencies of: AW/W handshake to REG_WEN, 1 cycle; REG_WEN to BVALID, 1 cycle; AR handshake to RVALID, 1 cycle.
REQ-021 SHALL keep REG_WEN all-zero in every state except W_EXEC.

Reset
REQ-022 While RSTN=0, SHALL immediately force both FSMs to their idle states, with BVALID=0, RVALID=0, REG_WEN=0, REG_WDATA=0, RDATA=0, BRESP=0, RRESP=0, and the captured address/data flags cleared.
REQ-023 SHALL set AWREADY, WREADY and ARREADY to 1 on the first clock after RSTN deasserts.
REQ-024 When reset is asserted mid-transaction, SHALL abandon the transaction without emitting REG_WEN or a response.

Verification
REQ-025 Bench SHALL write 0xDEADBEEF to 0x04 with WSTRB=0xF and AW/W together -> REG_WEN=0x02 for one cycle, REG_WDATA=0xDEADBEEF, BRESP=OKAY.
REQ-026 Bench SHALL write 0x000000AA to 0x00 with WSTRB=0x1 while reg0=0x12345678 -> REG_WDATA=0x123456AA.
REQ-027 Bench SHALL present W three cycles before AW to 0x1C -> a single REG_WEN=0x80 pulse and exactly one BVALID.
REQ-028 Bench SHALL write and then read 0x20 with NUM_REGS=8 -> no REG_WEN, BRESP=SLVERR, RDATA=0, RRESP=SLVERR.
REQ-029 Bench SHALL hold BREADY and RREADY low for 5 cycles -> BVALID, RVALID, RDATA and BRESP stay stable, and AWREADY and ARREADY stay 0.
REQ-030 Bench SHALL assert RSTN=0 in W_EXEC and during an AR handshake -> outputs go to reset values, and no response appears after reset.
